// File: rtl/module_mem_arbiter.sv
// Arbiter sharing one single-port memory between the fetch port and the data port.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants when both ports request at once.
module module_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_cancel_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_if_o,
  output logic              stall_mem_o
);
  // state   | meaning
  // IDLE    | no access; grant decision made here
  // BUSY_IF | fetch access on memory for MEM_LATENCY cycles
  // BUSY_DM | load/store access on memory for MEM_LATENCY cycles

  localparam int CNT_W = $clog2(MEM_LATENCY) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} arbState_t;

  arbState_t         state, stateNext;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic [ADDR_W-1:0] addrQ, addrNext;
  logic              weQ, weNext;
  logic [DATA_W-1:0] wdataQ, wdataNext;
  logic              cancelQ, cancelNext;
  logic              ifReqValid, grantDm, grantIf, lastCycle;

  assign ifReqValid = if_req_i & ~if_cancel_i;
  assign lastCycle  = (cnt == LAST_CNT);

`ifdef ARB_ROUND_ROBIN_EN
  logic lastGrantDm;

  // On a tie the port that lost the previous grant wins.
  assign grantDm = dm_req_i & (~ifReqValid | ~lastGrantDm);
  assign grantIf = ifReqValid & ~grantDm;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lastGrantDm <= 1'b0;
    end else if ((state == IDLE) && (grantDm || grantIf)) begin
      lastGrantDm <= grantDm;
    end
  end
`else
  assign grantDm = dm_req_i;
  assign grantIf = ifReqValid & ~dm_req_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      addrQ   <= '0;
      weQ     <= 1'b0;
      wdataQ  <= '0;
      cancelQ <= 1'b0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      addrQ   <= addrNext;
      weQ     <= weNext;
      wdataQ  <= wdataNext;
      cancelQ <= cancelNext;
    end
  end

  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    addrNext    = addrQ;
    weNext      = weQ;
    wdataNext   = wdataQ;
    cancelNext  = cancelQ;
    if_ack_o    = 1'b0;
    if_rdata_o  = '0;
    dm_ack_o    = 1'b0;
    dm_rdata_o  = '0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state)
      IDLE: begin
        cntNext    = '0;
        cancelNext = 1'b0;
        if (grantDm) begin
          stateNext = BUSY_DM;
          addrNext  = dm_addr_i;
          weNext    = dm_we_i;
          wdataNext = dm_wdata_i;
        end else if (grantIf) begin
          stateNext = BUSY_IF;
          addrNext  = if_addr_i;
          weNext    = 1'b0;
          wdataNext = '0;
        end
      end
      BUSY_IF: begin
        mem_en_o   = 1'b1;
        mem_addr_o = addrQ;
        cntNext    = cnt + CNT_W'(1);
        cancelNext = cancelQ | if_cancel_i;
        if (lastCycle) begin
          // A cancel in the final cycle also drops the ack.
          if_ack_o   = ~(cancelQ | if_cancel_i);
          if_rdata_o = if_ack_o ? mem_rdata_i : '0;
          stateNext  = IDLE;
          cntNext    = '0;
          cancelNext = 1'b0;
        end
      end
      BUSY_DM: begin
        mem_en_o    = 1'b1;
        mem_we_o    = weQ;
        mem_addr_o  = addrQ;
        mem_wdata_o = wdataQ;
        cntNext     = cnt + CNT_W'(1);
        if (lastCycle) begin
          dm_ack_o   = 1'b1;
          dm_rdata_o = weQ ? '0 : mem_rdata_i;
          stateNext  = IDLE;
          cntNext    = '0;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Stalls are gated by reset so every output is zero while reset is held.
  assign stall_if_o  = ~rst_i & if_req_i & ~if_ack_o & ~if_cancel_i;
  assign stall_mem_o = ~rst_i & dm_req_i & ~dm_ack_o;

endmodule
